floo_meta_table: RTL

- Out-of-order meta-information table for the chimney request/response path.
- Each accepted request is written into a free entry; the entry index becomes the outgoing transaction ID.
- Responses return in any order and index the table directly by ID.
- Generalises the single in-order FIFO plus per-atomic registers: configurable entry count, atomic reservation, multi-beat response release, occupancy tracking and an optional stale-entry watchdog.

---
 rtl/floo_meta_table.sv | 220 ++++++++++++++++++++++
 1 files changed

// File: rtl/floo_meta_table.sv
// floo_meta_table: out-of-order meta-information table for the chimney path.
// Each accepted request stores its meta in a free entry. That entry index is
// the outgoing transaction ID. Responses look up and release entries by ID in
// any order. The top NumAtopRsvd entries can only be taken by atomics.
//
// Optional feature: define FLOO_META_TABLE_TIMEOUT_EN to enable a per-entry
// age watchdog. When it is undefined, timeout_o and timeout_id_o are tied to 0.
//
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   test_enable_i        test mode (suppresses the request-stability check)
//   req_valid_i/_ready_o request handshake
//   req_is_atop_i        request is atomic (searches from the top, may use reserved entries)
//   req_buf_i            meta to store
//   req_id_o             ID offered to the current request
//   rsp_valid_i/_last_i  response beat; the last beat releases the entry
//   rsp_id_i             response ID
//   rsp_buf_o/_hit_o     meta and occupancy of entry rsp_id_i (combinational)
//   err_o                one-cycle pulse after a release of a free or out-of-range ID
//   usage_o, empty_o     occupancy count and empty flag
//   timeout_o/_id_o      sticky watchdog flag and first timed-out ID
module floo_meta_table #(
  parameter int unsigned NumEntries    = 8,
  parameter int unsigned NumAtopRsvd   = 1,
  parameter int unsigned IdWidth       = 3,
  parameter type         buf_t         = logic,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned UsageWidth   = $clog2(NumEntries + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  test_enable_i,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic                  req_is_atop_i,
  input  buf_t                  req_buf_i,
  output logic [IdWidth-1:0]    req_id_o,
  input  logic                  rsp_valid_i,
  input  logic                  rsp_last_i,
  input  logic [IdWidth-1:0]    rsp_id_i,
  output buf_t                  rsp_buf_o,
  output logic                  rsp_hit_o,
  output logic                  err_o,
  output logic [UsageWidth-1:0] usage_o,
  output logic                  empty_o,
  output logic                  timeout_o,
  output logic [IdWidth-1:0]    timeout_id_o
);

  localparam int unsigned IdxWidth   = $clog2(NumEntries);
  localparam int unsigned NumNonAtop = NumEntries - NumAtopRsvd;
  localparam int unsigned CmpWidth   = IdWidth + 1;

  logic [NumEntries-1:0] valid_q, valid_d;
  buf_t                  mem_q [NumEntries];
  logic [IdxWidth-1:0]   na_ptr_q, na_ptr_d, at_ptr_q, at_ptr_d;
  logic                  na_vld_q, na_vld_d, at_vld_q, at_vld_d;
  logic [UsageWidth-1:0] usage_q, usage_d;
  logic                  err_q, err_d;

  logic [IdxWidth-1:0]   sel_ptr;
  logic [IdxWidth-1:0]   rsp_idx;
  logic                  handshake, rsp_in_range, release_ok, release_err;
  logic [NumEntries-1:0] free_mask;
  logic [IdxWidth-1:0]   na_idx, at_idx;
  logic                  na_found, at_found;

  // Request side: the offered ID comes from a registered pointer.
  assign sel_ptr     = req_is_atop_i ? at_ptr_q : na_ptr_q;
  assign req_ready_o = req_is_atop_i ? at_vld_q : na_vld_q;
  assign req_id_o    = IdWidth'(sel_ptr);
  assign handshake   = req_valid_i && req_ready_o;

  // Response side: direct lookup by ID. IDs beyond the table never hit.
  assign rsp_in_range = ({1'b0, rsp_id_i} < CmpWidth'(NumEntries));
  assign rsp_idx      = IdxWidth'(rsp_id_i);
  assign rsp_hit_o    = rsp_in_range && valid_q[rsp_idx];
  assign rsp_buf_o    = rsp_in_range ? mem_q[rsp_idx] : buf_t'('0);
  assign release_ok   = rsp_valid_i && rsp_last_i && rsp_hit_o;
  assign release_err  = rsp_valid_i && rsp_last_i && !rsp_hit_o;

  assign usage_o = usage_q;
  assign empty_o = (usage_q == '0);
  assign err_o   = err_q;

  // Free-entry search. The entry taken this cycle is excluded, so a pointer that
  // reloads on a handshake never offers the slot that was just consumed.
  always_comb begin
    free_mask = ~valid_q;
    if (handshake) free_mask[sel_ptr] = 1'b0;
    na_found = 1'b0;
    na_idx   = '0;
    at_found = 1'b0;
    at_idx   = '0;
    for (int unsigned i = 0; i < NumNonAtop; i++) begin
      if (free_mask[i] && !na_found) begin
        na_found = 1'b1;
        na_idx   = IdxWidth'(i);
      end
    end
    // Ascending scan: the last free hit wins, which is the highest free index.
    for (int unsigned i = 0; i < NumEntries; i++) begin
      if (free_mask[i]) begin
        at_found = 1'b1;
        at_idx   = IdxWidth'(i);
      end
    end
  end

  // Pointer reload. A pending request keeps a valid pointer, so req_id_o stays stable.
  // An unsuccessful search keeps the old index and only drops the valid bit.
  always_comb begin
    na_ptr_d = na_ptr_q;
    na_vld_d = na_vld_q;
    at_ptr_d = at_ptr_q;
    at_vld_d = at_vld_q;
    if (!req_valid_i || handshake || !na_vld_q) begin
      na_vld_d = na_found;
      if (na_found) na_ptr_d = na_idx;
    end
    if (!req_valid_i || handshake || !at_vld_q) begin
      at_vld_d = at_found;
      if (at_found) at_ptr_d = at_idx;
    end
  end

  // Occupancy, usage and error tracking. Allocation and release never hit the same entry.
  always_comb begin
    valid_d = valid_q;
    usage_d = usage_q;
    err_d   = release_err;
    if (handshake)  valid_d[sel_ptr] = 1'b1;
    if (release_ok) valid_d[rsp_idx] = 1'b0;
    if (handshake && !release_ok) begin
      usage_d = usage_q + UsageWidth'(1);
    end else if (!handshake && release_ok) begin
      usage_d = usage_q - UsageWidth'(1);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      valid_q  <= '0;
      na_ptr_q <= '0;
      na_vld_q <= 1'b0;
      at_ptr_q <= '0;
      at_vld_q <= 1'b0;
      usage_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      valid_q  <= valid_d;
      na_ptr_q <= na_ptr_d;
      na_vld_q <= na_vld_d;
      at_ptr_q <= at_ptr_d;
      at_vld_q <= at_vld_d;
      usage_q  <= usage_d;
      err_q    <= err_d;
    end
  end

  // Meta storage. The contents are only meaningful while the valid bit is set.
  always_ff @(posedge clk_i) begin
    if (handshake) mem_q[sel_ptr] <= req_buf_i;
  end

`ifdef FLOO_META_TABLE_TIMEOUT_EN
  localparam int unsigned CntWidth = $clog2(TimeoutCycles + 1);

  logic [CntWidth-1:0] age_q [NumEntries];
  logic [CntWidth-1:0] age_d [NumEntries];
  logic                timeout_q, timeout_d;
  logic [IdWidth-1:0]  timeout_id_q, timeout_id_d;

  // Per-entry age. The counter restarts on allocation and saturates at the threshold.
  // The flag latches the lowest expired index once and then holds it.
  always_comb begin
    timeout_d    = timeout_q;
    timeout_id_d = timeout_id_q;
    for (int unsigned i = 0; i < NumEntries; i++) begin
      age_d[i] = age_q[i];
      if (handshake && (sel_ptr == IdxWidth'(i))) begin
        age_d[i] = '0;
      end else if (valid_q[i] && (age_q[i] != CntWidth'(TimeoutCycles))) begin
        age_d[i] = age_q[i] + CntWidth'(1);
      end
      if (!timeout_d && valid_q[i] && (age_q[i] == CntWidth'(TimeoutCycles))) begin
        timeout_d    = 1'b1;
        timeout_id_d = IdWidth'(i);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < NumEntries; i++) age_q[i] <= '0;
      timeout_q    <= 1'b0;
      timeout_id_q <= '0;
    end else begin
      for (int unsigned i = 0; i < NumEntries; i++) age_q[i] <= age_d[i];
      timeout_q    <= timeout_d;
      timeout_id_q <= timeout_id_d;
    end
  end

  assign timeout_o    = timeout_q;
  assign timeout_id_o = timeout_id_q;
`else
  assign timeout_o    = 1'b0;
  assign timeout_id_o = '0;
`endif

  // Parameter sanity and requester stability.
  a_id_width : assert property (@(posedge clk_i) IdWidth >= $clog2(NumEntries));
  a_rsvd     : assert property (@(posedge clk_i) NumAtopRsvd < NumEntries);
  a_entries  : assert property (@(posedge clk_i) NumEntries >= 2);
  a_timeout  : assert property (@(posedge clk_i) TimeoutCycles > 0);
  a_req_stab : assert property (@(posedge clk_i) disable iff (rst_i || test_enable_i)
                                (req_valid_i && !req_ready_o) |=> $stable(req_buf_i));

endmodule
